uart_icap_rx: RTL
=================

# uart_icap_rx

Host-to-FPGA receive path for the ICAP test harness. It deserialises 8N1 UART bytes and parses ASCII hex lines into 34-bit ICAP command words of the form {CSIB, RDWRB, I[31:0]}. It presents each word on a valid/ready port to whatever sequencer drives the ICAPE2 primitive. It is the inbound counterpart of the existing hex-dump UART transmitter and uses the same line rate and the same 34-bit word layout.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 16.
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset.
- uart_rx  in  1  asynchronous serial input; idles high.
- word_data  out  34  parsed word {CSIB, RDWRB, data[31:0]}.
- word_valid  out  1  word_data holds an unconsumed word.
- word_ready  in  1  consumer accepts the word when high together with word_valid.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parse_err  out  1  one-cycle pulse: malformed line discarded.
- overflow  out  1  one-cycle pulse: a completed word was dropped because the output register was full.

## Operation
- uart_rx passes through a 2-FF synchroniser; all logic below uses the synchronised bit.
- Byte receiver states:
  - IDLE: wait for a low level.
  - START: sample at CLKS_PER_BIT/2. If the line is high, it was a false start; return to IDLE.
  - DATA: 8 samples spaced CLKS_PER_BIT apart, LSB first.
  - STOP: sample after a further CLKS_PER_BIT. If high, strobe the byte. If low, pulse frame_err, drop the byte and go to WAIT_HIGH.
  - WAIT_HIGH: return to IDLE on the first high sample.
- Line parser, per strobed byte:
  - '0'-'9', 'A'-'F', 'a'-'f': digit. Increment the 4-bit digit count (saturates at 15) and shift the value into a 36-bit accumulator.
  - Space, '.' and '_': ignored.
  - LF (0x0A) or CR (0x0D): terminator, evaluated as follows.
    - Count 0 and the line is not poisoned: no action. This covers CRLF and blank lines.
    - Count exactly 9, first digit ≤ 3, not poisoned: emit word = accumulator[33:0].
    - Anything else: pulse parse_err.
    - In every case, clear the count and the poison flag.
  - Any other byte: set poison. parse_err pulses once, at the terminator.
- Output register:
  - An emitted word loads when word_valid=0, or when word_valid=1 and word_ready=1 in the same cycle.
  - Otherwise the new word is dropped, overflow pulses, and the held word is unchanged.
  - A handshake with no new word clears word_valid.
  - word_data holds its last value after a handshake.

## Timing
- Reset values: word_data=34'h3FFFFFFFF (ICAP idle), word_valid=0, frame_err=parse_err=overflow=0, receiver in IDLE, digit count 0, poison 0.
- rst mid-byte or mid-line discards the partial byte and line. The receiver re-arms on the next falling edge once the line is high.
- Byte strobe asserts for one cycle in the mid-stop-bit sample cycle.
- The parser consumes the strobe in the same cycle.
- word_valid, parse_err and overflow assert in the cycle after the terminator strobe.
- frame_err asserts in the cycle after the bad stop sample.
- The receiver accepts back-to-back bytes with no idle gap: it returns to IDLE at mid-stop.
- Error pulses are never merged; at most one error per byte.

## Structure
- Package uart_icap_pkg holds:
  - CLKS_PER_BIT default.
  - ICAP_WORD_W = 34.
  - ICAP_IDLE_WORD = 34'h3FFFFFFFF.
  - ASCII constants LF, CR, SP, DOT, USCORE.
  - Receiver state enum.
- Sub-module uart_rx_byte contains the synchroniser, the receiver FSM, byte/strobe output and frame_err. The parser and output register live in uart_icap_rx.

## Test plan
- Send "0AA995566\r\n" at 115200 baud → exactly one word_data=34'h0AA995566, word_valid for one handshake, no error pulses.
- Send "3ffff_ffff\n" then "1.2000.0000\n" → words 34'h3FFFFFFFF then 34'h120000000, in order.
- Send "0AA99556\n", "4AA995566\n" and "0AA9G5566\n" → three parse_err pulses and no words.
- Send byte 0x30 with the stop bit forced low, then "012345678\n" → one frame_err, then word 34'h012345678. The orphan '0' is dropped, so the count is exactly 9.
- Hold word_ready=0 and send two valid lines → first word held, one overflow pulse. Assert word_ready in the cycle the second word completes on a third line → no overflow, third word loaded.
- Assert rst for 1 cycle during data bit 4 of a byte → outputs return to reset values; the next full line parses correctly.

Source files
------------

// File: rtl/uart_icap_pkg.sv
// Shared constants, types and helpers for the ICAP UART receive path.
package uart_icap_pkg;

  // Default clock cycles per UART bit: 100 MHz / 115200 baud.
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // ICAP command word layout {CSIB, RDWRB, I[31:0]} and its idle value.
  localparam int                     ICAP_WORD_W    = 34;
  localparam logic [ICAP_WORD_W-1:0] ICAP_IDLE_WORD = 34'h3FFFFFFFF;

  // ASCII bytes with special meaning to the line parser.
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] SP     = 8'h20;
  localparam logic [7:0] DOT    = 8'h2E;
  localparam logic [7:0] USCORE = 8'h5F;

  // Byte receiver states.
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  // Result of decoding one ASCII character as a hex digit.
  typedef struct packed {
    logic       valid;
    logic [3:0] value;
  } hex_t;

  function automatic hex_t decode_hex(input logic [7:0] c);
    hex_t h;
    h.valid = 1'b1;
    h.value = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      h.value = 4'(c - 8'h30);
    end else if (c >= 8'h41 && c <= 8'h46) begin
      h.value = 4'(c - 8'h37);
    end else if (c >= 8'h61 && c <= 8'h66) begin
      h.value = 4'(c - 8'h57);
    end else begin
      h.valid = 1'b0;
    end
    return h;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: synchroniser, bit-timing FSM, byte strobe and
// framing-error pulse. CLKS_PER_BIT must be at least 16.
module uart_rx_byte
  import uart_icap_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err
);

  localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1, rx_s, armed;
  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic             frame_err_n;

  // Synchronise the line; 'armed' blocks start detection after reset until
  // the line has been seen high, so a reset mid-byte cannot start on a data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      rx_s  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
      armed <= armed | rx_s;
    end
  end

  // Receiver state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      frame_err <= frame_err_n;
    end
  end

  // Next-state logic; the strobe fires in the mid-stop sample cycle so the
  // receiver is back in IDLE in time for a back-to-back start bit.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt + 1'b1;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    frame_err_n = 1'b0;
    rx_strobe   = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (armed && !rx_s) state_n = RX_START;
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL_LAST) begin
          cnt_n     = '0;
          shreg_n   = {rx_s, shreg[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            rx_strobe = 1'b1;
            state_n   = RX_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = RX_WAIT_HIGH;
          end
        end
      end
      RX_WAIT_HIGH: begin
        cnt_n = '0;
        if (rx_s) state_n = RX_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = RX_IDLE;
      end
    endcase
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/uart_icap_rx.sv
// ICAP receive path: UART bytes -> ASCII hex line parser -> 34-bit command
// word held in a valid/ready output register.
module uart_icap_rx
  import uart_icap_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   uart_rx,
  output logic [ICAP_WORD_W-1:0] word_data,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   frame_err,
  output logic                   parse_err,
  output logic                   overflow
);

  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic [3:0]  digit_cnt;
  logic [35:0] acc;
  logic        poison;
  hex_t        hex;
  logic        is_term, is_ignored, emit, bad_line;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .frame_err (frame_err)
  );

  // Classify the strobed byte and decide what a terminator does; with exactly
  // nine digits the first one sits in acc[35:32], so it must be <= 3.
  always_comb begin
    hex        = decode_hex(rx_byte);
    is_term    = rx_strobe && (rx_byte == LF || rx_byte == CR);
    is_ignored = (rx_byte == SP) || (rx_byte == DOT) || (rx_byte == USCORE);
    emit       = is_term && !poison && (digit_cnt == 4'd9) && (acc[35:34] == 2'b00);
    bad_line   = is_term && !emit && !((digit_cnt == 4'd0) && !poison);
  end

  // Line parser: accumulate digits, remember junk until the terminator.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_cnt <= 4'd0;
      acc       <= '0;
      poison    <= 1'b0;
    end else if (rx_strobe) begin
      if (is_term) begin
        digit_cnt <= 4'd0;
        poison    <= 1'b0;
      end else if (hex.valid) begin
        acc <= {acc[31:0], hex.value};
        if (digit_cnt != 4'hF) digit_cnt <= digit_cnt + 4'd1;
      end else if (!is_ignored) begin
        poison <= 1'b1;
      end
    end
  end

  // Output register: a new word replaces a held one only if it is being
  // consumed this cycle; otherwise the new word is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_data  <= ICAP_IDLE_WORD;
      word_valid <= 1'b0;
      parse_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parse_err <= bad_line;
      overflow  <= 1'b0;
      if (emit) begin
        if (!word_valid || word_ready) begin
          word_data  <= acc[ICAP_WORD_W-1:0];
          word_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule
